// File: rtl/bar_pkg.sv
// bar_pkg: shared sizes, bar height type and fetch FSM states for bar_height_fetch
package bar_pkg;
  localparam int NUM_BARS   = 20;
  localparam int HEIGHT_W   = 6;
  localparam int MAX_HEIGHT = 63;
  typedef logic [HEIGHT_W-1:0] bar_height_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_SWAP} fetch_state_t;
endpackage

// File: rtl/bar_height_fetch_lane.sv
// bar_decay_lane: combines one bar's fetched height with its displayed height at swap time
//   i_shadow  : height captured from vga_ram (unclamped)
//   i_current : height currently displayed
//   o_next    : value loaded into the display buffer at swap
// Macro BAR_PEAK_DECAY_EN: when defined, bars jump up instantly and fall by 1 per swap.
module bar_decay_lane import bar_pkg::*; #(
  parameter int MAX_HEIGHT = bar_pkg::MAX_HEIGHT
) (
  input  bar_height_t i_shadow,
  input  bar_height_t i_current,
  output bar_height_t o_next
);
  bar_height_t w_clamped;
  assign w_clamped = (i_shadow > bar_height_t'(MAX_HEIGHT)) ? bar_height_t'(MAX_HEIGHT) : i_shadow;
`ifdef BAR_PEAK_DECAY_EN
  bar_height_t w_decayed;
  assign w_decayed = (i_current == '0) ? '0 : i_current - 1'b1;
  assign o_next    = (w_clamped > w_decayed) ? w_clamped : w_decayed;
`else
  logic w_unused_current;
  assign w_unused_current = ^i_current;
  assign o_next           = w_clamped;
`endif
endmodule

// File: rtl/bar_height_fetch.sv
// bar_height_fetch: fetches NUM_BARS heights from vga_ram on each data_back rise, swaps at vsync
//   i_clk, i_reset_n   : clock, asynchronous active-low reset
//   i_data_back        : Nios flag, a rising edge requests a fetch
//   i_vs_start         : 1-cycle pulse at start of vertical blank, triggers the swap
//   o_ram_rdaddress    : vga_ram read address (holds outside FETCH)
//   i_ram_q            : vga_ram read data, RAM_LATENCY cycles after the address
//   o_height           : display heights, bar i at [i*HEIGHT_W +: HEIGHT_W]
//   o_height_valid     : set by the first swap
//   o_busy             : FSM not in IDLE
//   o_overrun          : sticky, a data_back edge was merged into an already pending fetch
// Macro BAR_PEAK_DECAY_EN: enables peak-decay combining in bar_decay_lane.
module bar_height_fetch import bar_pkg::*; #(
  parameter int ADDR_W      = 6,
  parameter int RAM_LATENCY = 2,
  parameter int MAX_HEIGHT  = bar_pkg::MAX_HEIGHT
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_data_back,
  input  logic                         i_vs_start,
  output logic [ADDR_W-1:0]            o_ram_rdaddress,
  input  logic [HEIGHT_W-1:0]          i_ram_q,
  output logic [NUM_BARS*HEIGHT_W-1:0] o_height,
  output logic                         o_height_valid,
  output logic                         o_busy,
  output logic                         o_overrun
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BARS - 1);
  fetch_state_t r_state, w_next;
  logic r_db_q, r_pending, r_valid, r_overrun;
  logic w_edge, w_last_cap, w_swap;
  logic [ADDR_W-1:0] r_addr;
  logic [RAM_LATENCY-1:0] r_pv;
  logic [ADDR_W-1:0] r_pidx [RAM_LATENCY];
  logic [NUM_BARS-1:0][HEIGHT_W-1:0] r_shadow, r_height, w_next_h;
  assign w_edge     = i_data_back & ~r_db_q;
  // DRAIN ends on the cycle the last index leaves the capture pipe
  assign w_last_cap = r_pv[RAM_LATENCY-1] & (r_pidx[RAM_LATENCY-1] == LAST);
  assign w_swap     = (r_state == WAIT_SWAP) & i_vs_start;
  assign o_ram_rdaddress = r_addr;
  assign o_height        = r_height;
  assign o_height_valid  = r_valid;
  assign o_busy          = (r_state != IDLE);
  assign o_overrun       = r_overrun;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      w_next = (w_edge | r_pending) ? FETCH : IDLE;
      FETCH:     w_next = (r_addr == LAST) ? DRAIN : FETCH;
      DRAIN:     w_next = w_last_cap ? WAIT_SWAP : DRAIN;
      WAIT_SWAP: w_next = i_vs_start ? IDLE : WAIT_SWAP;
      default:   w_next = IDLE;
    endcase
  end
  for (genvar i = 0; i < NUM_BARS; i++) begin : g_lane
    bar_decay_lane #(.MAX_HEIGHT(MAX_HEIGHT)) u_lane (
      .i_shadow (r_shadow[i]),
      .i_current(r_height[i]),
      .o_next   (w_next_h[i])
    );
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_db_q    <= 1'b0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_pv      <= '0;
      r_shadow  <= '0;
      r_height  <= '0;
      for (int k = 0; k < RAM_LATENCY; k++) r_pidx[k] <= '0;
    end else begin
      r_db_q    <= i_data_back;
      // IDLE consumes the pending request; edges while busy collapse into one
      r_pending <= (r_state == IDLE) ? 1'b0 : (r_pending | w_edge);
      r_overrun <= r_overrun | (w_edge & r_pending);
      if (r_state == IDLE && (w_edge || r_pending)) r_addr <= '0;
      else if (r_state == FETCH && r_addr != LAST) r_addr <= r_addr + 1'b1;
      r_pv[0]   <= (r_state == FETCH);
      r_pidx[0] <= r_addr;
      for (int k = 1; k < RAM_LATENCY; k++) begin
        r_pv[k]   <= r_pv[k-1];
        r_pidx[k] <= r_pidx[k-1];
      end
      for (int i = 0; i < NUM_BARS; i++)
        if (r_pv[RAM_LATENCY-1] && r_pidx[RAM_LATENCY-1] == ADDR_W'(i)) r_shadow[i] <= i_ram_q;
      if (w_swap) begin
        r_height <= w_next_h;
        r_valid  <= 1'b1;
      end
    end
endmodule

// File: tb/tb_bar_height_fetch.sv
// tb_bar_height_fetch: scoreboard bench for bar_height_fetch with a latency-accurate vga_ram model
module tb_bar_height_fetch;
  localparam int N = 20, W = 6, L = 2, MAXH = 40;
  logic clk = 0, reset_n = 0, data_back = 0, vs_start = 0;
  logic [5:0] addr, ram_q;
  logic [N*W-1:0] height, model_h, disp, exp_h;
  logic hv, busy, ovr, prev_busy;
  logic [5:0] mem [64];
  logic [5:0] rq [L];
  logic [N*W-1:0] sb [$];
  int n_checks = 0, n_fail = 0;

  bar_height_fetch #(.ADDR_W(6), .RAM_LATENCY(L), .MAX_HEIGHT(MAXH)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_data_back(data_back), .i_vs_start(vs_start),
    .o_ram_rdaddress(addr), .i_ram_q(ram_q), .o_height(height),
    .o_height_valid(hv), .o_busy(busy), .o_overrun(ovr)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    rq[0] <= mem[addr];
    for (int k = 1; k < L; k++) rq[k] <= rq[k-1];
  end
  assign ram_q = rq[L-1];

  task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] predict(input logic [N*W-1:0] prev);
    logic [N*W-1:0] r;
    logic [5:0] c, d;
    for (int i = 0; i < N; i++) begin
      c = (mem[i] > 6'(MAXH)) ? 6'(MAXH) : mem[i];
      d = prev[i*W +: W];
`ifdef BAR_PEAK_DECAY_EN
      d = (d == 0) ? 6'd0 : d - 6'd1;
      c = (c > d) ? c : d;
`endif
      r[i*W +: W] = c;
    end
    return r;
  endfunction

  task automatic push_exp();
    model_h = predict(model_h);
    sb.push_back(model_h);
  endtask

  always @(negedge clk or negedge reset_n)
    if (!reset_n) prev_busy <= 1'b0;
    else begin
      if (prev_busy && !busy) begin
        check("sb_nonempty", 120'(sb.size() != 0), 120'(1));
        if (sb.size() != 0) begin
          exp_h = sb.pop_front();
          check("swap_height", height, exp_h);
          check("swap_valid", 120'(hv), 120'(1));
          disp = exp_h;
        end
      end
      prev_busy <= busy;
    end

  task automatic raise();
    @(posedge clk); #1 data_back = 1;
    push_exp();
  endtask

  task automatic swap();
    @(posedge clk); #1 vs_start = 1;
    @(posedge clk); #1 vs_start = 0;
    @(negedge clk);
  endtask

  task automatic frame();
    raise();
    repeat (3) @(posedge clk);
    #1 data_back = 0;
    repeat (20 + L) @(posedge clk);
    @(negedge clk);
    check("hold_busy", 120'(busy), 120'(1));
    check("hold_height", height, disp);
    swap();
    check("idle_busy", 120'(busy), 120'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_h = '0;
    disp = '0;
    for (int i = 0; i < 64; i++) mem[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_height", height, 0);
    check("rst_valid", 120'(hv), 120'(0));
    check("rst_busy", 120'(busy), 120'(0));
    check("rst_overrun", 120'(ovr), 120'(0));
    check("rst_addr", 120'(addr), 120'(0));
    reset_n = 1;
    // basic fetch with address walk
    for (int i = 0; i < N; i++) mem[i] = 6'(i + 1);
    raise();
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("walk_addr", 120'(addr), 120'(k));
    end
    data_back = 0;
    repeat (L + 2) @(posedge clk);
    @(negedge clk);
    check("hold_height", height, disp);
    swap();
    check("idle_busy", 120'(busy), 120'(0));
    check("addr_hold", 120'(addr), 120'(N - 1));
    // clamping
    mem[5] = 63;
    frame();
    // three edges during FETCH -> overrun, one extra fetch
    raise();
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1 data_back = 0;
      @(posedge clk); #1 data_back = 1;
    end
    @(posedge clk); #1 data_back = 0;
    repeat (20 + L) @(posedge clk);
    @(negedge clk);
    check("overrun_set", 120'(ovr), 120'(1));
    check("wait_busy", 120'(busy), 120'(1));
    for (int i = 0; i < N; i++) mem[i] = 6'(20 - i);
    push_exp();
    swap();
    @(negedge clk);
    check("refetch_busy", 120'(busy), 120'(1));
    check("refetch_addr", 120'(addr), 120'(0));
    repeat (22 + L) @(posedge clk);
    @(negedge clk);
    swap();
    repeat (30) @(negedge clk);
    check("no_third_fetch", 120'(busy), 120'(0));
    check("overrun_sticky", 120'(ovr), 120'(1));
    // vs_start during FETCH and in the DRAIN exit cycle are ignored
    for (int i = 0; i < N; i++) mem[i] = 6'(2 * i + 1);
    raise();
    repeat (5) @(posedge clk);
    #1 vs_start = 1;
    @(posedge clk); #1 vs_start = 0; data_back = 0;
    @(negedge clk);
    check("vs_fetch_height", height, disp);
    check("vs_fetch_busy", 120'(busy), 120'(1));
    repeat (14 + L) @(posedge clk);
    #1 vs_start = 1;
    @(posedge clk); #1 vs_start = 0;
    @(negedge clk);
    check("vs_drain_height", height, disp);
    check("vs_drain_busy", 120'(busy), 120'(1));
    repeat (3) @(posedge clk);
    swap();
    // reset mid-FETCH
    for (int i = 0; i < N; i++) mem[i] = 6'(i + 10);
    raise();
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("pre_reset_addr", 120'(addr), 120'(10));
    #2 reset_n = 0; data_back = 0;
    #1;
    check("mid_rst_height", height, 0);
    check("mid_rst_valid", 120'(hv), 120'(0));
    check("mid_rst_busy", 120'(busy), 120'(0));
    check("mid_rst_overrun", 120'(ovr), 120'(0));
    check("mid_rst_addr", 120'(addr), 120'(0));
    void'(sb.pop_back());
    model_h = '0;
    disp = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    frame();
    check("post_rst_overrun", 120'(ovr), 120'(0));
    // decay sequence: 30 then frames of 0
    for (int i = 0; i < N; i++) mem[i] = 6'd30;
    frame();
    for (int i = 0; i < N; i++) mem[i] = 6'd0;
    frame();
    frame();
    repeat (5) @(negedge clk);
    check("sb_empty", 120'(sb.size()), 120'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
